// File: rtl/store_merge.sv
// Sub-word store unit: truncates rt to byte/half and merges it into the addressed
// RAM word by read-modify-write; word stores write straight through.
module store_merge #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [31:0]       st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              addr_err
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned LANE_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    WR   = 3'd3,
    ERR  = 3'd4
  } state_t;

  state_t state, state_nx;

  logic              accept;
  logic              misaligned;
  logic [1:0]        cap_lane;
  logic              cap_half;
  logic [HALF_W-1:0] cap_data;
  logic [DATA_W-1:0] merged;
  logic              unused_addr_hi;

  // Address bits above the RAM word range carry no meaning for this RAM.
  assign unused_addr_hi = ^st_addr[31:ADDR_W+2];

  assign st_ready = (state == IDLE) && !reset;
  assign accept   = st_valid && st_ready;

  // Alignment check on the presented request.
  always_comb begin
    misaligned = 1'b0;
    case (st_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = st_addr[0];
      SZ_WORD: misaligned = (st_addr[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (misaligned)             state_nx = ERR;
          else if (st_size == SZ_WORD) state_nx = WR;
          else                        state_nx = RD;
        end
      end
      RD:      state_nx = WAIT;
      WAIT:    state_nx = WR;
      WR:      state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Lane merge of captured store data over the word read back from RAM.
  always_comb begin
    merged = mem_rdata;
    if (cap_half) begin
      if (cap_lane[1]) merged[31:16] = cap_data;
      else             merged[15:0]  = cap_data;
    end else begin
      case (cap_lane)
        2'd0:    merged[7:0]   = cap_data[LANE_W-1:0];
        2'd1:    merged[15:8]  = cap_data[LANE_W-1:0];
        2'd2:    merged[23:16] = cap_data[LANE_W-1:0];
        default: merged[31:24] = cap_data[LANE_W-1:0];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Strobes are decoded from the next state so they are clean flop outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_re   <= 1'b0;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      mem_re   <= (state_nx == RD);
      mem_we   <= (state_nx == WR);
      done     <= (state_nx == WR);
      addr_err <= (state_nx == ERR);
    end
  end

  // Request capture and write-data register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      cap_lane  <= '0;
      cap_half  <= 1'b0;
      cap_data  <= '0;
    end else begin
      if (accept) begin
        mem_addr <= st_addr[ADDR_W+1:2];
        cap_lane <= st_addr[1:0];
        cap_half <= (st_size == SZ_HALF);
        cap_data <= st_data[HALF_W-1:0];
        if ((st_size == SZ_WORD) && !misaligned) mem_wdata <= st_data;
      end
      if (state == WAIT) mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_store_merge.sv
// Self-checking bench for store_merge with a behavioural word RAM and a write scoreboard.
module tb_store_merge;

  localparam int unsigned ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              st_valid = 1'b0;
  logic              st_ready;
  logic [31:0]       st_addr = '0;
  logic [31:0]       st_data = '0;
  logic [1:0]        st_size = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic              done;
  logic              addr_err;

  store_merge #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata), .done(done), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  // Word RAM model; read data appears the cycle after mem_re.
  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_addr = '0;
  logic [31:0]       pre_data = '0;

  always @(posedge clk) begin
    if (pre_en)      ram[pre_addr] <= pre_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= ram[mem_addr];
  end

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [31:0]       d;
  } wr_t;

  wr_t exp_q[$];
  int  vectors = 0;
  int  errors  = 0;

  logic [31:0] byte_exp [4] = '{32'h1122_33AB, 32'h1122_AB44, 32'h11AB_3344, 32'hAB22_3344};
  logic [31:0] half_addr [2] = '{32'h0000_0006, 32'h0000_0004};
  logic [31:0] half_exp  [2] = '{32'hCAFE_3344, 32'h1122_CAFE};
  logic [31:0] err_addr  [3] = '{32'h0000_0003, 32'h0000_0002, 32'h0000_0000};
  logic [1:0]  err_size  [3] = '{2'b01, 2'b10, 2'b11};

  // Scoreboard: every RAM write must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && mem_we) begin
      wr_t e;
      vectors++;
      if (mem_re) begin
        errors++;
        $display("FAIL sb_re_we_overlap re=%0b we=%0b required re=0", mem_re, mem_we);
      end
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_write addr=%0h data=%h required no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== {e.a, e.d}) begin
          errors++;
          $display("FAIL sb_write got addr=%0h data=%h required addr=%0h data=%h",
                   mem_addr, mem_wdata, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_en   = 1'b1;
    tick();
    pre_en   = 1'b0;
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    st_addr  = a;
    st_data  = d;
    st_size  = s;
    st_valid = 1'b1;
    tick();
    st_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    vectors++;
    if ({mem_re, mem_we, done, addr_err, st_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got re/we/done/err/rdy=%b required 00000",
               {mem_re, mem_we, done, addr_err, st_ready});
    end
    vectors++;
    if ({mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr=%0h wdata=%h required 0", mem_addr, mem_wdata);
    end
    reset = 1'b0;
    tick();
    vectors++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", st_ready);
    end
  endtask

  task automatic test_word();
    exp_q.push_back('{a: 10'd2, d: 32'hDEAD_BEEF});
    apply(32'h0000_0008, 32'hDEAD_BEEF, 2'b10);
    vectors++;
    if ({mem_re, mem_we, done, addr_err, st_ready} !== 5'b01100) begin
      errors++;
      $display("FAIL word_k1_flags got re/we/done/err/rdy=%b required 01100",
               {mem_re, mem_we, done, addr_err, st_ready});
    end
    vectors++;
    if ({mem_addr, mem_wdata} !== {10'd2, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL word_k1_bus got addr=%0h wdata=%h required addr=2 wdata=deadbeef",
               mem_addr, mem_wdata);
    end
    tick();
    vectors++;
    if ({mem_re, mem_we, done, st_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL word_k2_flags got re/we/done/rdy=%b required 0001",
               {mem_re, mem_we, done, st_ready});
    end
  endtask

  task automatic rmw_store(input string name, input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] s, input logic [31:0] expw);
    preload(10'd1, 32'h1122_3344);
    exp_q.push_back('{a: 10'd1, d: expw});
    apply(a, d, s);
    vectors++;
    if ({mem_re, mem_we, done, st_ready, mem_addr} !== {4'b1000, 10'd1}) begin
      errors++;
      $display("FAIL %s_rd got re/we/done/rdy=%b addr=%0h required 1000 addr=1",
               name, {mem_re, mem_we, done, st_ready}, mem_addr);
    end
    tick();
    vectors++;
    if ({mem_re, mem_we, done} !== 3'b000) begin
      errors++;
      $display("FAIL %s_wait got re/we/done=%b required 000", name, {mem_re, mem_we, done});
    end
    tick();
    vectors++;
    if ({mem_re, mem_we, done, mem_wdata} !== {3'b011, expw}) begin
      errors++;
      $display("FAIL %s_wr got re/we/done=%b wdata=%h required 011 wdata=%h",
               name, {mem_re, mem_we, done}, mem_wdata, expw);
    end
    tick();
    vectors++;
    if ({st_ready, mem_we, done} !== 3'b100) begin
      errors++;
      $display("FAIL %s_ready got rdy/we/done=%b required 100", name, {st_ready, mem_we, done});
    end
  endtask

  task automatic test_byte();
    for (int i = 0; i < 4; i++)
      rmw_store($sformatf("byte_lane%0d", i), 32'h4 + 32'(i), 32'h1234_56AB, 2'b00, byte_exp[i]);
  endtask

  task automatic test_half();
    for (int i = 0; i < 2; i++)
      rmw_store($sformatf("half%0d", i), half_addr[i], 32'hFFFF_CAFE, 2'b01, half_exp[i]);
  endtask

  task automatic test_errors();
    for (int i = 0; i < 3; i++) begin
      apply(err_addr[i], 32'h5555_AAAA, err_size[i]);
      vectors++;
      if ({mem_re, mem_we, done, addr_err, st_ready} !== 5'b00010) begin
        errors++;
        $display("FAIL err%0d_k1 got re/we/done/err/rdy=%b required 00010",
                 i, {mem_re, mem_we, done, addr_err, st_ready});
      end
      tick();
      vectors++;
      if ({mem_re, mem_we, done, addr_err, st_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL err%0d_k2 got re/we/done/err/rdy=%b required 00001",
                 i, {mem_re, mem_we, done, addr_err, st_ready});
      end
    end
  endtask

  task automatic test_reset_mid();
    preload(10'd1, 32'h1122_3344);
    apply(32'h0000_0005, 32'h1234_56AB, 2'b00);
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if ({mem_re, mem_we, done, addr_err, st_ready, mem_addr, mem_wdata} !== '0) begin
      errors++;
      $display("FAIL rstmid_outputs got re/we/done/err/rdy=%b addr=%0h wdata=%h required all 0",
               {mem_re, mem_we, done, addr_err, st_ready}, mem_addr, mem_wdata);
    end
    tick();
    tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (ram[1] !== 32'h1122_3344) begin
      errors++;
      $display("FAIL rstmid_no_write got ram[1]=%h required 11223344", ram[1]);
    end
    exp_q.push_back('{a: 10'd4, d: 32'h0BAD_F00D});
    apply(32'h0000_0010, 32'h0BAD_F00D, 2'b10);
    vectors++;
    if ({done, mem_we, mem_addr} !== {2'b11, 10'd4}) begin
      errors++;
      $display("FAIL rstmid_after_sw got done/we=%b addr=%0h required 11 addr=4",
               {done, mem_we}, mem_addr);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    exp_q.push_back('{a: 10'd8,  d: 32'hAAAA_0001});
    exp_q.push_back('{a: 10'd10, d: 32'hCCCC_0003});
    st_size  = 2'b10;
    st_addr  = 32'h0000_0020;
    st_data  = 32'hAAAA_0001;
    st_valid = 1'b1;
    vectors++;
    if (st_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_k_ready got %b required 1", st_ready);
    end
    tick();
    st_addr = 32'h0000_0024;
    st_data = 32'hBBBB_0002;
    vectors++;
    if ({st_ready, mem_we, mem_wdata} !== {2'b01, 32'hAAAA_0001}) begin
      errors++;
      $display("FAIL b2b_k1 got rdy/we=%b wdata=%h required 01 wdata=aaaa0001",
               {st_ready, mem_we}, mem_wdata);
    end
    tick();
    vectors++;
    if ({st_ready, mem_we} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_k2 got rdy/we=%b required 10", {st_ready, mem_we});
    end
    st_addr = 32'h0000_0028;
    st_data = 32'hCCCC_0003;
    tick();
    st_valid = 1'b0;
    vectors++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 10'd10, 32'hCCCC_0003}) begin
      errors++;
      $display("FAIL b2b_k3 got we=%b addr=%0h wdata=%h required we=1 addr=a wdata=cccc0003",
               mem_we, mem_addr, mem_wdata);
    end
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending writes required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
